// File: rtl/demux_one_to_two_buffered_if.sv
// Handshake bundle for the buffered 1-to-2 demultiplexer: one producer side
// and two independent consumer channels, each with a delivered-word counter.
interface demux_one_to_two_buffered_if #(
  parameter int N_BITS   = 8,
  parameter int CNT_BITS = 8
);
  logic                In_Valid;
  logic                In_Ready;
  logic                Selector;
  logic [N_BITS-1:0]   Data_In;
  logic                Out0_Valid;
  logic                Out0_Ready;
  logic [N_BITS-1:0]   Data_0;
  logic                Out1_Valid;
  logic                Out1_Ready;
  logic [N_BITS-1:0]   Data_1;
  logic [CNT_BITS-1:0] Count_0;
  logic [CNT_BITS-1:0] Count_1;

  // The environment (producer plus both consumers) drives this side.
  modport master (
    output In_Valid, Selector, Data_In, Out0_Ready, Out1_Ready,
    input  In_Ready, Out0_Valid, Data_0, Out1_Valid, Data_1, Count_0, Count_1
  );

  modport slave (
    input  In_Valid, Selector, Data_In, Out0_Ready, Out1_Ready,
    output In_Ready, Out0_Valid, Data_0, Out1_Valid, Data_1, Count_0, Count_1
  );
endinterface

// File: rtl/demux_one_to_two_buffered.sv
// Registered 1-to-2 demultiplexer: each output channel owns a 2-entry FIFO so a
// stalled consumer never blocks the other channel, plus a wrapping pop counter.
module demux_one_to_two_buffered #(
  parameter int N_BITS   = 8,
  parameter int CNT_BITS = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  demux_one_to_two_buffered_if.slave     bus
);

  logic [1:0]          occ_q    [2];
  logic [1:0]          occ_d    [2];
  logic                rd_ptr_q [2];
  logic                rd_ptr_d [2];
  logic [N_BITS-1:0]   mem_q    [2][2];
  logic [N_BITS-1:0]   mem_d    [2][2];
  logic [CNT_BITS-1:0] cnt_q    [2];
  logic [CNT_BITS-1:0] cnt_d    [2];

  logic                push     [2];
  logic                pop      [2];
  logic                out_ready[2];
  logic                in_ready;

  // In_Ready looks only at registered occupancy, so there is no path from
  // either Out_Ready into In_Ready.
  always_comb begin
    out_ready[0] = bus.Out0_Ready;
    out_ready[1] = bus.Out1_Ready;
    in_ready     = bus.Selector ? (occ_q[1] != 2'd2) : (occ_q[0] != 2'd2);

    for (int c = 0; c < 2; c++) begin
      push[c]     = bus.In_Valid && in_ready && (bus.Selector == (c == 1));
      pop[c]      = (occ_q[c] != 2'd0) && out_ready[c];
      occ_d[c]    = occ_q[c];
      rd_ptr_d[c] = rd_ptr_q[c];
      cnt_d[c]    = cnt_q[c];
      mem_d[c][0] = mem_q[c][0];
      mem_d[c][1] = mem_q[c][1];

      // Tail slot is the head when empty and the other slot when one word is
      // held; a push is never allowed at occupancy 2.
      if (push[c]) begin
        mem_d[c][rd_ptr_q[c] ^ occ_q[c][0]] = bus.Data_In;
      end

      if (pop[c]) begin
        rd_ptr_d[c] = ~rd_ptr_q[c];
        cnt_d[c]    = cnt_q[c] + 1'b1;
      end

      case ({push[c], pop[c]})
        2'b10:   occ_d[c] = occ_q[c] + 2'd1;
        2'b01:   occ_d[c] = occ_q[c] - 2'd1;
        default: occ_d[c] = occ_q[c];
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        occ_q[c]    <= 2'd0;
        rd_ptr_q[c] <= 1'b0;
        cnt_q[c]    <= '0;
        mem_q[c][0] <= '0;
        mem_q[c][1] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        occ_q[c]    <= occ_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        cnt_q[c]    <= cnt_d[c];
        mem_q[c][0] <= mem_d[c][0];
        mem_q[c][1] <= mem_d[c][1];
      end
    end
  end

  assign bus.In_Ready   = in_ready;
  assign bus.Out0_Valid = (occ_q[0] != 2'd0);
  assign bus.Out1_Valid = (occ_q[1] != 2'd0);
  assign bus.Data_0     = (occ_q[0] != 2'd0) ? mem_q[0][rd_ptr_q[0]] : '0;
  assign bus.Data_1     = (occ_q[1] != 2'd0) ? mem_q[1][rd_ptr_q[1]] : '0;
  assign bus.Count_0    = cnt_q[0];
  assign bus.Count_1    = cnt_q[1];

endmodule

// File: tb/tb_demux_one_to_two_buffered.sv
// Directed bench for the buffered demultiplexer: one 8-bit-counter instance for
// routing/backpressure and one 2-bit-counter instance for counter wrap.
module tb_demux_one_to_two_buffered;

  logic clk;
  logic reset;
  int   assertCount;
  int   failCount;

  demux_one_to_two_buffered_if #(.N_BITS(8), .CNT_BITS(8)) bus8 ();
  demux_one_to_two_buffered_if #(.N_BITS(8), .CNT_BITS(2)) bus2 ();

  demux_one_to_two_buffered #(.N_BITS(8), .CNT_BITS(8)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave)
  );

  demux_one_to_two_buffered #(.N_BITS(8), .CNT_BITS(2)) u_dut_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic valid, input logic sel, input logic [7:0] data);
    bus8.In_Valid = valid;
    bus8.Selector = sel;
    bus8.Data_In  = data;
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    reset       = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00);
    bus8.Out0_Ready = 1'b0;
    bus8.Out1_Ready = 1'b0;
    bus2.In_Valid   = 1'b0;
    bus2.Selector   = 1'b0;
    bus2.Data_In    = 8'h00;
    bus2.Out0_Ready = 1'b0;
    bus2.Out1_Ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();

    // Idle after reset
    checkOutput("rst_v0",  32'(bus8.Out0_Valid), 32'd0);
    checkOutput("rst_v1",  32'(bus8.Out1_Valid), 32'd0);
    checkOutput("rst_d0",  32'(bus8.Data_0),     32'd0);
    checkOutput("rst_d1",  32'(bus8.Data_1),     32'd0);
    checkOutput("rst_c0",  32'(bus8.Count_0),    32'd0);
    checkOutput("rst_c1",  32'(bus8.Count_1),    32'd0);
    checkOutput("rst_rdy_s0", 32'(bus8.In_Ready), 32'd1);
    bus8.Selector = 1'b1;
    #1;
    checkOutput("rst_rdy_s1", 32'(bus8.In_Ready), 32'd1);

    // Single word through channel 0
    step();
    applyStimulus(1'b1, 1'b0, 8'hA5);
    bus8.Out0_Ready = 1'b1;
    #1;
    checkOutput("a5_rdy", 32'(bus8.In_Ready), 32'd1);
    step();
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("a5_v0", 32'(bus8.Out0_Valid), 32'd1);
    checkOutput("a5_d0", 32'(bus8.Data_0),     32'hA5);
    checkOutput("a5_v1", 32'(bus8.Out1_Valid), 32'd0);
    checkOutput("a5_c0_pre", 32'(bus8.Count_0), 32'd0);
    step();
    checkOutput("a5_c0",    32'(bus8.Count_0),    32'd1);
    checkOutput("a5_v0_end", 32'(bus8.Out0_Valid), 32'd0);

    // Fill channel 0 while its consumer stalls
    bus8.Out0_Ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h11);
    step();
    applyStimulus(1'b1, 1'b0, 8'h22);
    step();
    applyStimulus(1'b1, 1'b0, 8'h33);
    #1;
    checkOutput("full_rdy", 32'(bus8.In_Ready), 32'd0);
    checkOutput("full_d0",  32'(bus8.Data_0),   32'h11);
    step();
    checkOutput("stall_d0",  32'(bus8.Data_0),     32'h11);
    checkOutput("stall_v0",  32'(bus8.Out0_Valid), 32'd1);
    checkOutput("stall_rdy", 32'(bus8.In_Ready),   32'd0);

    // Channel 1 is not blocked by the full channel 0
    applyStimulus(1'b1, 1'b1, 8'h7E);
    bus8.Out1_Ready = 1'b1;
    #1;
    checkOutput("ch1_rdy", 32'(bus8.In_Ready), 32'd1);
    step();
    checkOutput("ch1_v1", 32'(bus8.Out1_Valid), 32'd1);
    checkOutput("ch1_d1", 32'(bus8.Data_1),     32'h7E);
    checkOutput("ch1_d0", 32'(bus8.Data_0),     32'h11);
    checkOutput("ch1_v0", 32'(bus8.Out0_Valid), 32'd1);

    // Drain channel 0; 0x33 is taken once a slot frees up
    applyStimulus(1'b1, 1'b0, 8'h33);
    bus8.Out0_Ready = 1'b1;
    #1;
    checkOutput("drain_rdy0", 32'(bus8.In_Ready), 32'd0);
    step();
    checkOutput("drain_d0a",  32'(bus8.Data_0),     32'h22);
    checkOutput("drain_rdy1", 32'(bus8.In_Ready),   32'd1);
    checkOutput("drain_c1",   32'(bus8.Count_1),    32'd1);
    checkOutput("drain_v1",   32'(bus8.Out1_Valid), 32'd0);
    step();
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("drain_d0b", 32'(bus8.Data_0),     32'h33);
    checkOutput("drain_v0b", 32'(bus8.Out0_Valid), 32'd1);
    step();
    checkOutput("drain_v0c", 32'(bus8.Out0_Valid), 32'd0);
    checkOutput("drain_c0",  32'(bus8.Count_0),    32'd4);

    // Full-rate streaming: one word per cycle with occupancy held at 1
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(i));
      #1;
      checkOutput($sformatf("stream_rdy%0d", i), 32'(bus8.In_Ready), 32'd1);
      step();
      checkOutput($sformatf("stream_d%0d", i), 32'(bus8.Data_0),     32'(i));
      checkOutput($sformatf("stream_v%0d", i), 32'(bus8.Out0_Valid), 32'd1);
    end
    applyStimulus(1'b0, 1'b0, 8'h00);
    step();
    checkOutput("stream_v_end", 32'(bus8.Out0_Valid), 32'd0);
    checkOutput("stream_c0",    32'(bus8.Count_0),    32'd9);

    // Two-bit counter wraps 1,2,3,0,1
    bus2.Out1_Ready = 1'b1;
    bus2.Selector   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus2.In_Valid = 1'b1;
      bus2.Data_In  = 8'(8'h40 + i);
      step();
      checkOutput($sformatf("wrap_d%0d", i), 32'(bus2.Data_1), 32'(8'h40 + i));
      if (i > 0) begin
        checkOutput($sformatf("wrap_c%0d", i), 32'(bus2.Count_1), 32'(i % 4));
      end
    end
    bus2.In_Valid = 1'b0;
    step();
    checkOutput("wrap_c5", 32'(bus2.Count_1), 32'd1);

    // Asynchronous reset with both channels holding words
    bus8.Out0_Ready = 1'b0;
    bus8.Out1_Ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'hC1);
    step();
    applyStimulus(1'b1, 1'b0, 8'hC2);
    step();
    applyStimulus(1'b1, 1'b1, 8'hD1);
    step();
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("pre_rst_v0", 32'(bus8.Out0_Valid), 32'd1);
    checkOutput("pre_rst_d1", 32'(bus8.Data_1),     32'hD1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("arst_v0", 32'(bus8.Out0_Valid), 32'd0);
    checkOutput("arst_v1", 32'(bus8.Out1_Valid), 32'd0);
    checkOutput("arst_d0", 32'(bus8.Data_0),     32'd0);
    checkOutput("arst_d1", 32'(bus8.Data_1),     32'd0);
    checkOutput("arst_c0", 32'(bus8.Count_0),    32'd0);
    checkOutput("arst_c1", 32'(bus8.Count_1),    32'd0);
    checkOutput("arst_wrap_c1", 32'(bus2.Count_1), 32'd0);
    step();
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 8'h3C);
    bus8.Out1_Ready = 1'b1;
    step();
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("post_rst_v1", 32'(bus8.Out1_Valid), 32'd1);
    checkOutput("post_rst_d1", 32'(bus8.Data_1),     32'h3C);
    checkOutput("post_rst_v0", 32'(bus8.Out0_Valid), 32'd0);
    step();
    checkOutput("post_rst_c1", 32'(bus8.Count_1),    32'd1);
    checkOutput("post_rst_v1e", 32'(bus8.Out1_Valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/demux_one_to_two_buffered.md
Name: demux_one_to_two_buffered

Overview:
- Registered 1-to-2 demultiplexer with valid/ready handshakes; the write-direction counterpart of the MEM-stage 2:1 read mux.
- Routes one input word to output channel 0 (e.g. data memory) or channel 1 (e.g. I/O port), selected by Selector.
- Each channel has a 2-entry FIFO, so one stalled consumer does not block traffic to the other channel.
- Each channel keeps a wrap-around delivered-word counter for debug and performance monitoring.

Parameters:
- N_BITS, 8, data word width.
- CNT_BITS, 8, width of each per-channel delivered-word counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- In_Valid  input  1  producer presents a word.
- In_Ready  output  1  block accepts the word this cycle.
- Selector  input  1  destination: 0 = channel 0, 1 = channel 1. Sampled only when In_Valid=1.
- Data_In  input  N_BITS  input word.
- Out0_Valid  output  1  channel 0 head word valid.
- Out0_Ready  input  1  channel 0 consumer accepts.
- Data_0  output  N_BITS  channel 0 head word.
- Out1_Valid  output  1  channel 1 head word valid.
- Out1_Ready  input  1  channel 1 consumer accepts.
- Data_1  output  N_BITS  channel 1 head word.
- Count_0  output  CNT_BITS  channel 0 delivered words.
- Count_1  output  CNT_BITS  channel 1 delivered words.

Behaviour:
- Reset (asynchronous, any cycle, including mid-transfer): both FIFOs emptied and storage cleared to 0. Out0_Valid = Out1_Valid = 0, Data_0 = Data_1 = 0, Count_0 = Count_1 = 0. All buffered words are discarded.
- Per-channel state: occupancy occ_x in {0,1,2}, two entry registers, one read pointer bit.
- In_Ready = (Selector==0) ? (occ_0 < 2) : (occ_1 < 2).
  - Uses registered occupancy only; a same-cycle pop does not raise In_Ready (no combinational path from Out_Ready to In_Ready).
  - In_Ready is combinational on Selector.
- Push: In_Valid && In_Ready at an edge writes Data_In into the selected channel's tail entry and increments occ.
- Out_x_Valid = (occ_x != 0). Data_x = head entry when valid, else 0.
- Latency: a word accepted at edge k is visible on Data_x / Out_x_Valid after edge k. Minimum one cycle, no bypass.
- Pop: Out_x_Valid && Out_x_Ready at an edge advances the head and decrements occ_x. The pop also increments Count_x, wrapping from 2^CNT_BITS-1 to 0.
- Simultaneous push and pop on the same channel: occ_x unchanged, head advances, new word appended behind the remaining word. FIFO order is preserved.
- Pushes to one channel and pops from the other in the same cycle are independent.
- Word order is preserved within a channel; there is no ordering guarantee between channels.
- Stall: while Out_x_Valid=1 and Out_x_Ready=0, Data_x stays stable and Out_x_Valid stays 1.
- Full channel (occ=2) with In_Valid on it: In_Ready=0, word not taken, no state change. The producer must hold Data_In and Selector until accepted.
- Out_x_Ready asserted while empty: ignored, counter unchanged.
- Throughput: one word per cycle per channel when the consumer is always ready (steady state occ=1).

Test Plan:
- Reset, then idle: all Valid=0, Data_0 = Data_1 = 0, counts 0, In_Ready=1 for both Selector values.
- Push 0xA5 with Selector=0 while Out0_Ready=1:
  - Cycle after acceptance: Out0_Valid=1, Data_0=0xA5, Out1_Valid=0.
  - Next edge: Count_0=1, Out0_Valid=0.
- Out0_Ready=0, push 0x11, 0x22, 0x33 to channel 0:
  - First two are accepted; In_Ready=0 on the third. Data_0 holds 0x11.
  - Raise Out0_Ready: 0x11, 0x22 delivered in order, then 0x33 is accepted.
- Channel 0 full and stalled, push 0x7E with Selector=1 and Out1_Ready=1: accepted immediately, Data_1=0x7E next cycle, channel 0 contents unchanged.
- With occ_0=1 and Out0_Ready=1, push each cycle 0x01..0x05 to channel 0: one word delivered per cycle in order, occ_0 stays 1.
- Counter wrap: with CNT_BITS=2, deliver 5 words on channel 1 → Count_1 sequence 1,2,3,0,1.
- Reset mid-operation: assert reset with occ_0=2, occ_1=1 → immediately all Valid=0, Data outputs 0, counts 0. After release, a push 0x3C to channel 1 is delivered normally.
